// File: rtl/m2_block_scheduler_pkg.sv
// m2_block_scheduler_pkg: state encoding and segment codes shared by the
// milestone-2 block scheduler and its block pointers.
package m2_block_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LI_FETCH,
        S_LI_CT,
        S_MEGA_A,
        S_MEGA_B,
        S_LO_CS,
        S_LO_WS
    } m2_sched_state_type;

    localparam logic [1:0] SEG_Y    = 2'd0;
    localparam logic [1:0] SEG_U    = 2'd1;
    localparam logic [1:0] SEG_V    = 2'd2;
    localparam logic [1:0] SEG_PAST = 2'd3;

endpackage

// File: rtl/m2_block_scheduler_counter.sv
// m2_block_counter: walks (seg,row,col) over Y, U, V blocks in raster order
// and parks at seg=SEG_PAST once the last V block has been passed.
module m2_block_counter
    import m2_block_scheduler_pkg::*;
#(
    parameter int Y_COLS  = 40,
    parameter int UV_COLS = 20,
    parameter int ROWS    = 30
) (
    input  logic       CLOCK_50_I,
    input  logic       resetn,
    input  logic       i_clear,
    input  logic       i_advance,
    output logic [1:0] o_seg,
    output logic [4:0] o_row,
    output logic [5:0] o_col,
    output logic       o_past_last
);

    logic [1:0] r_seg;
    logic [4:0] r_row;
    logic [5:0] r_col;
    logic [5:0] w_last_col;
    logic       w_col_end;
    logic       w_row_end;

    assign w_last_col  = (r_seg == SEG_Y) ? 6'(Y_COLS - 1) : 6'(UV_COLS - 1);
    assign w_col_end   = (r_col == w_last_col);
    assign w_row_end   = (r_row == 5'(ROWS - 1));
    assign o_past_last = (r_seg == SEG_PAST);
    assign o_seg       = r_seg;
    assign o_row       = r_row;
    assign o_col       = r_col;

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_seg <= SEG_Y;
            r_row <= 5'd0;
            r_col <= 6'd0;
        end else if (i_clear) begin
            r_seg <= SEG_Y;
            r_row <= 5'd0;
            r_col <= 6'd0;
        end else if (i_advance && !o_past_last) begin
            if (!w_col_end) begin
                r_col <= r_col + 6'd1;
            end else begin
                r_col <= 6'd0;
                r_row <= w_row_end ? 5'd0 : r_row + 5'd1;
                if (w_row_end)
                    r_seg <= r_seg + 2'd1;
            end
        end
    end

endmodule

// File: rtl/m2_block_scheduler.sv
// m2_block_scheduler: sequences fetch / compute-T / compute-S / write-S over
// every 8x8 block, overlapping block k with block k-1 in the MEGA states.
module m2_block_scheduler
    import m2_block_scheduler_pkg::*;
#(
    parameter int Y_COLS  = 40,
    parameter int UV_COLS = 20,
    parameter int ROWS    = 30
) (
    input  logic       CLOCK_50_I,
    input  logic       resetn,
    input  logic       m2_start,
    output logic       m2_end,
    output logic       busy,
    output logic       fetch_start,
    input  logic       fetch_done,
    output logic       ct_start,
    input  logic       ct_done,
    output logic       cs_start,
    input  logic       cs_done,
    output logic       ws_start,
    input  logic       ws_done,
    output logic [1:0] fetch_seg,
    output logic [4:0] fetch_row,
    output logic [5:0] fetch_col,
    output logic [1:0] ws_seg,
    output logic [4:0] ws_row,
    output logic [5:0] ws_col
);

    m2_sched_state_type r_state;
    logic r_d0;
    logic r_d1;
    logic w_d0;
    logic w_d1;
    logic w_both;
    logic w_clear;
    logic w_fetch_adv;
    logic w_ws_adv;
    logic w_fetch_past;
    logic w_ws_past;

    // MEGA_A pairs (fetch, cs); MEGA_B pairs (ct, ws); flags hold whichever arrived first
    assign w_d0        = (r_state == S_MEGA_A) ? fetch_done : ct_done;
    assign w_d1        = (r_state == S_MEGA_A) ? cs_done : ws_done;
    assign w_both      = (r_d0 | w_d0) & (r_d1 | w_d1);
    assign w_clear     = (r_state == S_IDLE) && m2_start;
    assign w_fetch_adv = ((r_state == S_LI_FETCH) && fetch_done) || ((r_state == S_MEGA_A) && w_both);
    assign w_ws_adv    = (r_state == S_MEGA_B) && w_both;

    m2_block_counter #(.Y_COLS(Y_COLS), .UV_COLS(UV_COLS), .ROWS(ROWS)) u_fetch_ptr (
        .CLOCK_50_I (CLOCK_50_I),
        .resetn     (resetn),
        .i_clear    (w_clear),
        .i_advance  (w_fetch_adv),
        .o_seg      (fetch_seg),
        .o_row      (fetch_row),
        .o_col      (fetch_col),
        .o_past_last(w_fetch_past)
    );

    m2_block_counter #(.Y_COLS(Y_COLS), .UV_COLS(UV_COLS), .ROWS(ROWS)) u_ws_ptr (
        .CLOCK_50_I (CLOCK_50_I),
        .resetn     (resetn),
        .i_clear    (w_clear),
        .i_advance  (w_ws_adv),
        .o_seg      (ws_seg),
        .o_row      (ws_row),
        .o_col      (ws_col),
        .o_past_last(w_ws_past)
    );

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_d0        <= 1'b0;
            r_d1        <= 1'b0;
            m2_end      <= 1'b0;
            busy        <= 1'b0;
            fetch_start <= 1'b0;
            ct_start    <= 1'b0;
            cs_start    <= 1'b0;
            ws_start    <= 1'b0;
        end else begin
            m2_end      <= 1'b0;
            fetch_start <= 1'b0;
            ct_start    <= 1'b0;
            cs_start    <= 1'b0;
            ws_start    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    busy <= m2_start;
                    if (m2_start) begin
                        fetch_start <= 1'b1;
                        r_state     <= S_LI_FETCH;
                    end
                end
                S_LI_FETCH: if (fetch_done) begin
                    ct_start <= 1'b1;
                    r_state  <= S_LI_CT;
                end
                S_LI_CT: if (ct_done) begin
                    cs_start    <= 1'b1;
                    fetch_start <= !w_fetch_past;
                    r_state     <= w_fetch_past ? S_LO_CS : S_MEGA_A;
                end
                S_MEGA_A, S_MEGA_B: begin
                    if (w_both) begin
                        r_d0 <= 1'b0;
                        r_d1 <= 1'b0;
                        if (r_state == S_MEGA_A) begin
                            ct_start <= 1'b1;
                            ws_start <= 1'b1;
                            r_state  <= S_MEGA_B;
                        end else begin
                            cs_start    <= 1'b1;
                            fetch_start <= !w_fetch_past;
                            r_state     <= w_fetch_past ? S_LO_CS : S_MEGA_A;
                        end
                    end else begin
                        r_d0 <= r_d0 | w_d0;
                        r_d1 <= r_d1 | w_d1;
                    end
                end
                S_LO_CS: if (cs_done) begin
                    ws_start <= 1'b1;
                    r_state  <= S_LO_WS;
                end
                S_LO_WS: if (ws_done) begin
                    m2_end  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic w_unused;
    assign w_unused = w_ws_past;

endmodule

// File: tb/tb_m2_block_scheduler.sv
// tb_m2_block_scheduler: random-latency engines against a group-level model of
// the block schedule, plus a literal trace of a 3-block instance.
module tb_m2_block_scheduler;

    localparam int YC = 40;
    localparam int UVC = 20;
    localparam int NR = 30;
    localparam int N = NR * (YC + 2 * UVC);
    localparam int NG = 2 * N + 2;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic m2_start = 1'b0;
    logic fetch_done = 1'b0, ct_done = 1'b0, cs_done = 1'b0, ws_done = 1'b0;
    logic m2_end, busy, fetch_start, ct_start, cs_start, ws_start;
    logic [1:0] fetch_seg, ws_seg;
    logic [4:0] fetch_row, ws_row;
    logic [5:0] fetch_col, ws_col;

    logic s_start = 1'b0;
    logic s_end, s_busy, s_f, s_t, s_s, s_w;
    logic [1:0] s_fs, s_wss;
    logic [4:0] s_fr, s_wr;
    logic [5:0] s_fc, s_wc;

    always #5 clk = ~clk;

    m2_block_scheduler #(.Y_COLS(YC), .UV_COLS(UVC), .ROWS(NR)) dut (
        .CLOCK_50_I(clk), .resetn(resetn), .m2_start(m2_start), .m2_end(m2_end), .busy(busy),
        .fetch_start(fetch_start), .fetch_done(fetch_done), .ct_start(ct_start), .ct_done(ct_done),
        .cs_start(cs_start), .cs_done(cs_done), .ws_start(ws_start), .ws_done(ws_done),
        .fetch_seg(fetch_seg), .fetch_row(fetch_row), .fetch_col(fetch_col),
        .ws_seg(ws_seg), .ws_row(ws_row), .ws_col(ws_col)
    );

    // engines that answer in the very cycle their start is seen
    m2_block_scheduler #(.Y_COLS(1), .UV_COLS(1), .ROWS(1)) dut_small (
        .CLOCK_50_I(clk), .resetn(resetn), .m2_start(s_start), .m2_end(s_end), .busy(s_busy),
        .fetch_start(s_f), .fetch_done(s_f), .ct_start(s_t), .ct_done(s_t),
        .cs_start(s_s), .cs_done(s_s), .ws_start(s_w), .ws_done(s_w),
        .fetch_seg(s_fs), .fetch_row(s_fr), .fetch_col(s_fc),
        .ws_seg(s_wss), .ws_row(s_wr), .ws_col(s_wc)
    );

    int vectors = 0, miscompares = 0;
    int g;
    logic [3:0] pend, exp_st;
    logic exp_end, exp_busy;
    int cnt[4];
    int nf, nt, ns, nw, ne;
    logic [12:0] last_ws;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // block index -> {seg,row,col}, raster order within Y then U then V
    function automatic logic [12:0] blk(input int k);
        int s, base, cols;
        if (k < NR * YC) begin s = 0; base = 0; cols = YC; end
        else if (k < NR * (YC + UVC)) begin s = 1; base = NR * YC; cols = UVC; end
        else begin s = 2; base = NR * (YC + UVC); cols = UVC; end
        return {2'(s), 5'((k - base) / cols), 6'((k - base) % cols)};
    endfunction

    // starts of group g: even = {F(g/2), S(g/2-1)}, odd = {T(g/2), W(g/2-1)}; bits {W,S,T,F}
    function automatic logic [3:0] grp(input int gi);
        logic [3:0] m;
        int b;
        m = 4'b0;
        b = gi / 2;
        if (gi % 2 == 0) begin m[0] = (b < N); m[2] = (b >= 1); end
        else begin m[1] = (b < N); m[3] = (b >= 1); end
        return m;
    endfunction

    task automatic step(input logic start_in, input logic [3:0] inj);
        logic [3:0] d, m;
        logic had, idle_now;
        int e;
        @(negedge clk);
        chk("fetch_start", fetch_start, exp_st[0]);
        chk("ct_start", ct_start, exp_st[1]);
        chk("cs_start", cs_start, exp_st[2]);
        chk("ws_start", ws_start, exp_st[3]);
        chk("m2_end", m2_end, exp_end);
        chk("busy", busy, exp_busy);
        if (exp_st[0]) chk("fetch_ptr", {fetch_seg, fetch_row, fetch_col}, blk(g / 2));
        if (exp_st[3]) chk("ws_ptr", {ws_seg, ws_row, ws_col}, blk(g / 2 - 1));
        nf += int'(fetch_start); nt += int'(ct_start); ns += int'(cs_start); nw += int'(ws_start); ne += int'(m2_end);
        if (ws_start) last_ws = {ws_seg, ws_row, ws_col};
        if (exp_st != 4'b0) begin
            pend = exp_st;
            for (int i = 0; i < 4; i++) cnt[i] = $urandom_range(0, 4);
            if (g == 4) begin cnt[0] = 6; cnt[2] = 1; end
            if (g == 6) begin cnt[0] = 3; cnt[2] = 3; end
        end
        had = (pend != 4'b0);
        d = inj;
        for (int i = 0; i < 4; i++)
            if (pend[i]) begin
                if (cnt[i] == 0) begin d[i] = 1'b1; pend[i] = 1'b0; end
                else cnt[i]--;
            end
        // strays only on engines the current group does not wait for
        m = (g >= 0) ? grp(g) : 4'b0;
        e = $urandom_range(0, 3);
        if ($urandom_range(0, 7) == 0 && !m[e]) d[e] = 1'b1;
        {ws_done, cs_done, ct_done, fetch_done} = d;
        m2_start = start_in;
        idle_now = (g < 0);
        exp_st = 4'b0;
        exp_end = 1'b0;
        if (start_in && idle_now) begin
            g = 0;
            exp_st = grp(0);
        end else if (had && pend == 4'b0) begin
            g++;
            if (g < NG) exp_st = grp(g);
            else begin exp_end = 1'b1; g = -1; end
        end
        exp_busy = (g >= 0) || exp_end;
    endtask

    task automatic do_reset();
        #2;
        resetn = 1'b0;
        {ws_done, cs_done, ct_done, fetch_done} = 4'b0;
        m2_start = 1'b0;
        #1;
        chk("rst_starts", {m2_end, busy, fetch_start, ct_start, cs_start, ws_start}, 0);
        chk("rst_fetch_ptr", {fetch_seg, fetch_row, fetch_col}, 0);
        chk("rst_ws_ptr", {ws_seg, ws_row, ws_col}, 0);
        g = -1; pend = 4'b0; exp_st = 4'b0; exp_end = 1'b0; exp_busy = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        logic [5:0] small_exp [10];
        int cycles;
        small_exp = '{6'b100001, 6'b100010, 6'b100101, 6'b101010, 6'b100101,
                      6'b101010, 6'b100100, 6'b101000, 6'b110000, 6'b000000};
        g = -1; pend = 4'b0; exp_st = 4'b0; exp_end = 1'b0; exp_busy = 1'b0;
        nf = 0; nt = 0; ns = 0; nw = 0; ne = 0; last_ws = '0;
        do_reset();
        chk("blk_1199", blk(1199), {2'd0, 5'd29, 6'd39});
        chk("blk_1200", blk(1200), {2'd1, 5'd0, 6'd0});
        chk("blk_1799", blk(1799), {2'd1, 5'd29, 6'd19});
        chk("blk_1800", blk(1800), {2'd2, 5'd0, 6'd0});
        chk("grp_last", grp(NG - 1), 4'b1000);

        s_start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            s_start = 1'b0;
            chk("small_trace", {s_busy, s_end, s_w, s_s, s_t, s_f}, small_exp[i]);
            if (i == 4) chk("small_fetch_ptr", {s_fs, s_fr, s_fc}, {2'd2, 5'd0, 6'd0});
            if (i == 7) chk("small_ws_ptr", {s_wss, s_wr, s_wc}, {2'd2, 5'd0, 6'd0});
        end

        step(1'b1, 4'b0);
        cycles = 0;
        while (!(g >= 51 && g % 2 == 1 && pend != 4'b0 && exp_st == 4'b0) && cycles < 2000) begin
            step(1'b0, 4'b0);
            cycles++;
        end
        chk("reach_mega_b", cycles < 2000, 1);
        do_reset();
        step(1'b0, 4'b1000);
        repeat (3) step(1'b0, 4'b0);

        nf = 0; nt = 0; ns = 0; nw = 0; ne = 0;
        step(1'b1, 4'b0);
        cycles = 0;
        while (g >= 0 && cycles < 60000) begin
            step($urandom_range(0, 31) == 0, 4'b0);
            cycles++;
        end
        chk("run_finished", g < 0, 1);
        repeat (4) step(1'b0, 4'b0);
        chk("fetch_count", nf, N);
        chk("ct_count", nt, N);
        chk("cs_count", ns, N);
        chk("ws_count", nw, N);
        chk("m2_end_count", ne, 1);
        chk("last_ws", last_ws, {2'd2, 5'd29, 6'd19});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
